// File: rtl/execute_stage_md_if.sv
// E-stage bundle between the D/E register, hazard unit and memory stage of the
// 5-stage RV32 pipeline: E-side controls/operands in, stall/redirect and E/M register out.
interface execute_stage_md_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  RegWriteE;
   logic                  MemWriteE;
   logic                  ResultSrcE;
   logic                  ALUSrcE;
   logic                  BranchE;
   logic                  JumpE;
   logic [2:0]            BranchOpE;
   logic [2:0]            ALUControlE;
   logic                  MulDivE;
   logic [2:0]            MulDivOpE;
   logic [XLEN-1:0]       RD1_E;
   logic [XLEN-1:0]       RD2_E;
   logic [XLEN-1:0]       Imm_Ext_E;
   logic [REG_ADDR_W-1:0] RD_E;
   logic [XLEN-1:0]       PCE;
   logic [XLEN-1:0]       PCPlus4E;
   logic [XLEN-1:0]       ResultW;
   logic [1:0]            ForwardA_E;
   logic [1:0]            ForwardB_E;
   logic                  StallE;
   logic                  PCSrcE;
   logic [XLEN-1:0]       PCTargetE;
   logic                  RegWriteM;
   logic                  MemWriteM;
   logic                  ResultSrcM;
   logic [REG_ADDR_W-1:0] RD_M;
   logic [XLEN-1:0]       PCPlus4M;
   logic [XLEN-1:0]       WriteDataM;
   logic [XLEN-1:0]       ALUResultM;

   modport master (
      output RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE, BranchOpE,
             ALUControlE, MulDivE, MulDivOpE, RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE,
             PCPlus4E, ResultW, ForwardA_E, ForwardB_E,
      input  StallE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
             PCPlus4M, WriteDataM, ALUResultM
   );

   modport slave (
      input  RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE, BranchOpE,
             ALUControlE, MulDivE, MulDivOpE, RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE,
             PCPlus4E, ResultW, ForwardA_E, ForwardB_E,
      output StallE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
             PCPlus4M, WriteDataM, ALUResultM
   );
endinterface

// File: rtl/execute_stage_md.sv
// RV32 execute stage with forwarding, branch/jump resolution, iterative MUL/DIV unit
// and E/M register. Optional macro SIGNED_MULDIV_EN enables signed MULH/MULHSU/DIV/REM.
module execute_stage_md #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input logic               clk,
   input logic               rst,
   execute_stage_md_if.slave bus
);
   localparam int CNT_W = $clog2(XLEN + 1);

   typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;

   state_t                state;
   state_t                state_next;
   logic                  stall;
   logic [XLEN-1:0]       src_a;
   logic [XLEN-1:0]       src_b_fwd;
   logic [XLEN-1:0]       src_b;
   logic [XLEN-1:0]       alu_result;
   logic                  cond;
   logic                  div_zero;
   logic [XLEN-1:0]       mag_a;
   logic [XLEN-1:0]       mag_b;
   logic [2:0]            op;
   logic [REG_ADDR_W-1:0] rd;
   logic                  reg_write;
   logic                  mem_write;
   logic                  result_src;
   logic [XLEN-1:0]       pc_plus4;
   logic [XLEN-1:0]       write_data;
   logic [XLEN-1:0]       divisor;
   logic [XLEN-1:0]       acc_hi;
   logic [XLEN-1:0]       acc_lo;
   logic [CNT_W-1:0]      count;
   logic [XLEN:0]         mul_sum;
   logic [XLEN:0]         div_shift;
   logic                  div_ge;
   logic [XLEN-1:0]       div_diff;
   logic [2*XLEN-1:0]     product;
   logic [XLEN-1:0]       quotient;
   logic [XLEN-1:0]       remainder;
   logic [XLEN-1:0]       md_result;

   // forwarding muxes and ALU source select
   always_comb begin
      case (bus.ForwardA_E)
         2'b01:   src_a = bus.ResultW;
         2'b10:   src_a = bus.ALUResultM;
         default: src_a = bus.RD1_E;
      endcase
      case (bus.ForwardB_E)
         2'b01:   src_b_fwd = bus.ResultW;
         2'b10:   src_b_fwd = bus.ALUResultM;
         default: src_b_fwd = bus.RD2_E;
      endcase
      src_b = bus.ALUSrcE ? bus.Imm_Ext_E : src_b_fwd;
   end

   // single-cycle ALU
   always_comb begin
      case (bus.ALUControlE)
         3'b000:  alu_result = src_a + src_b;
         3'b001:  alu_result = src_a - src_b;
         3'b010:  alu_result = src_a & src_b;
         3'b011:  alu_result = src_a | src_b;
         3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         default: alu_result = '0;
      endcase
   end

   // branch condition on the forwarded register operands
   always_comb begin
      case (bus.BranchOpE)
         3'b000:  cond = (src_a == src_b_fwd);
         3'b001:  cond = (src_a != src_b_fwd);
         3'b100:  cond = ($signed(src_a) < $signed(src_b_fwd));
         3'b101:  cond = ($signed(src_a) >= $signed(src_b_fwd));
         3'b110:  cond = (src_a < src_b_fwd);
         3'b111:  cond = (src_a >= src_b_fwd);
         default: cond = 1'b0;
      endcase
   end

   assign bus.PCSrcE    = ~bus.MulDivE & (bus.JumpE | (bus.BranchE & cond));
   assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;
   assign div_zero      = bus.MulDivOpE[2] & (src_b_fwd == '0);

`ifdef SIGNED_MULDIV_EN
   logic sign_a;
   logic sign_b;
   logic neg_res;
   logic neg_rem;

   // operand signs: MULH/MULHSU/DIV/REM treat rs1 as signed, MULH/DIV/REM also rs2
   always_comb begin
      sign_a = src_a[XLEN-1] & ((bus.MulDivOpE == 3'b001) | (bus.MulDivOpE == 3'b010) |
                                (bus.MulDivOpE == 3'b100) | (bus.MulDivOpE == 3'b110));
      sign_b = src_b_fwd[XLEN-1] & ((bus.MulDivOpE == 3'b001) | (bus.MulDivOpE == 3'b100) |
                                    (bus.MulDivOpE == 3'b110));
      mag_a  = sign_a ? -src_a : src_a;
      mag_b  = sign_b ? -src_b_fwd : src_b_fwd;
   end

   // result sign flags; cleared on divide by zero so the fixed results pass through
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
      end else if ((state == IDLE) && bus.MulDivE) begin
         neg_res <= ~div_zero & (sign_a ^ sign_b);
         neg_rem <= ~div_zero & sign_a & bus.MulDivOpE[2];
      end
   end

   // sign-magnitude post correction
   always_comb begin
      product   = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      quotient  = neg_res ? -acc_lo : acc_lo;
      remainder = neg_rem ? -acc_hi : acc_hi;
   end
`else
   assign mag_a     = src_a;
   assign mag_b     = src_b_fwd;
   assign product   = {acc_hi, acc_lo};
   assign quotient  = acc_lo;
   assign remainder = acc_hi;
`endif

   // one shift-add or restoring-division step on the shared accumulator pair
   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, divisor} : {(XLEN+1){1'b0}});
   assign div_shift = {acc_hi, acc_lo[XLEN-1]};
   assign div_ge    = (div_shift >= {1'b0, divisor});
   assign div_diff  = div_shift[XLEN-1:0] - divisor;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // next state and stall
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.MulDivE) begin
               stall      = 1'b1;
               state_next = div_zero ? DONE : BUSY;
            end else begin
               state_next = IDLE;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (count == CNT_W'(1'b1)) state_next = DONE;
            else                       state_next = BUSY;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign bus.StallE = stall & rst;

   // capture on entry, iterate while busy, hold in DONE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op         <= 3'b000;
         rd         <= '0;
         reg_write  <= 1'b0;
         mem_write  <= 1'b0;
         result_src <= 1'b0;
         pc_plus4   <= '0;
         write_data <= '0;
         divisor    <= '0;
         acc_hi     <= '0;
         acc_lo     <= '0;
         count      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.MulDivE) begin
                  op         <= bus.MulDivOpE;
                  rd         <= bus.RD_E;
                  reg_write  <= bus.RegWriteE;
                  mem_write  <= bus.MemWriteE;
                  result_src <= bus.ResultSrcE;
                  pc_plus4   <= bus.PCPlus4E;
                  write_data <= src_b_fwd;
                  count      <= CNT_W'(XLEN);
                  if (div_zero) begin
                     divisor <= '0;
                     acc_hi  <= src_a;
                     acc_lo  <= '1;
                  end else if (bus.MulDivOpE[2]) begin
                     divisor <= mag_b;
                     acc_hi  <= '0;
                     acc_lo  <= mag_a;
                  end else begin
                     divisor <= mag_a;
                     acc_hi  <= '0;
                     acc_lo  <= mag_b;
                  end
               end
            end
            BUSY: begin
               count <= count - CNT_W'(1'b1);
               if (op[2]) begin
                  acc_hi <= div_ge ? div_diff : div_shift[XLEN-1:0];
                  acc_lo <= {acc_lo[XLEN-2:0], div_ge};
               end else begin
                  {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
               end
            end
            default: begin
               count <= count;
            end
         endcase
      end
   end

   // result selection by funct3
   always_comb begin
      case (op)
         3'b000:          md_result = product[XLEN-1:0];
         3'b001, 3'b010,
         3'b011:          md_result = product[2*XLEN-1:XLEN];
         3'b100, 3'b101:  md_result = quotient;
         3'b110, 3'b111:  md_result = remainder;
         default:         md_result = '0;
      endcase
   end

   // E/M register: bubble while stalled, MUL/DIV result in DONE, ALU result otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.RegWriteM  <= 1'b0;
         bus.MemWriteM  <= 1'b0;
         bus.ResultSrcM <= 1'b0;
         bus.RD_M       <= '0;
         bus.PCPlus4M   <= '0;
         bus.WriteDataM <= '0;
         bus.ALUResultM <= '0;
      end else if (stall) begin
         bus.RegWriteM <= 1'b0;
         bus.MemWriteM <= 1'b0;
         bus.RD_M      <= '0;
      end else if (state == DONE) begin
         bus.RegWriteM  <= reg_write;
         bus.MemWriteM  <= mem_write;
         bus.ResultSrcM <= result_src;
         bus.RD_M       <= rd;
         bus.PCPlus4M   <= pc_plus4;
         bus.WriteDataM <= write_data;
         bus.ALUResultM <= md_result;
      end else begin
         bus.RegWriteM  <= bus.RegWriteE;
         bus.MemWriteM  <= bus.MemWriteE;
         bus.ResultSrcM <= bus.ResultSrcE;
         bus.RD_M       <= bus.RD_E;
         bus.PCPlus4M   <= bus.PCPlus4E;
         bus.WriteDataM <= src_b_fwd;
         bus.ALUResultM <= alu_result;
      end
   end
endmodule

// File: tb/tb_execute_stage_md.sv
// Directed self-checking bench for execute_stage_md: ALU/forwarding, branches, MUL/DIV
// latency and results (signed set when SIGNED_MULDIV_EN is defined), mid-operation reset.
module tb_execute_stage_md;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic [31:0] pc4;
      int          stalls;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   execute_stage_md_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

   execute_stage_md #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_e();
      bus.RegWriteE   = 1'b0;
      bus.MemWriteE   = 1'b0;
      bus.ResultSrcE  = 1'b0;
      bus.ALUSrcE     = 1'b0;
      bus.BranchE     = 1'b0;
      bus.JumpE       = 1'b0;
      bus.BranchOpE   = 3'b000;
      bus.ALUControlE = 3'b000;
      bus.MulDivE     = 1'b0;
      bus.MulDivOpE   = 3'b000;
      bus.RD1_E       = 32'h0;
      bus.RD2_E       = 32'h0;
      bus.Imm_Ext_E   = 32'h0;
      bus.RD_E        = 5'd0;
      bus.PCE         = 32'h0;
      bus.PCPlus4E    = 32'h0;
      bus.ResultW     = 32'h0;
      bus.ForwardA_E  = 2'b00;
      bus.ForwardB_E  = 2'b00;
   endtask

   // independent reference using native arithmetic
   function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [63:0] pu;
      logic [31:0] r;
      pu = {32'h0, a} * {32'h0, b};
      case (op)
         3'b000: r = pu[31:0];
         3'b011: r = pu[63:32];
         3'b101: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         3'b111: r = (b == 32'h0) ? a : a % b;
`ifdef SIGNED_MULDIV_EN
         3'b001: begin
            logic signed [63:0] ps;
            ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            r  = ps[63:32];
         end
         3'b010: begin
            logic signed [63:0] psu;
            psu = $signed({{32{a[31]}}, a}) * $signed({32'h0, b});
            r   = psu[63:32];
         end
         3'b100: begin
            if (b == 32'h0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = $signed(a) / $signed(b);
         end
         3'b110: begin
            if (b == 32'h0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else r = $signed(a) % $signed(b);
         end
`else
         3'b001, 3'b010: r = pu[63:32];
         3'b100: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         3'b110: r = (b == 32'h0) ? a : a % b;
`endif
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   // wait out the stall (bounded), then compare the E/M register against the scoreboard
   task automatic collect(input string tag);
      exp_t e;
      int   stalls = 0;
      logic bubble_ok = 1'b1;
      #1;
      while (bus.StallE === 1'b1 && stalls < 100) begin
         stalls++;
         @(posedge clk);
         #1;
         if (bus.RegWriteM !== 1'b0 || bus.MemWriteM !== 1'b0 || bus.RD_M !== 5'd0)
            bubble_ok = 1'b0;
         bus.RD1_E = $urandom;
         bus.RD2_E = $urandom;
      end
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check({tag, " stall cycles"}, stalls, e.stalls);
      check({tag, " bubble"}, {31'h0, bubble_ok}, 32'h1);
      check({tag, " ALUResultM"}, bus.ALUResultM, e.res);
      check({tag, " RD_M"}, {27'h0, bus.RD_M}, {27'h0, e.rd});
      check({tag, " RegWriteM"}, {31'h0, bus.RegWriteM}, 32'h1);
      check({tag, " PCPlus4M"}, bus.PCPlus4M, e.pc4);
   endtask

   task automatic issue_alu(input string tag, input logic [2:0] ctl, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] imm, input logic alusrc,
                            input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] rw,
                            input logic [4:0] rd, input logic [31:0] exp_res);
      exp_t e;
      clear_e();
      bus.ALUControlE = ctl;
      bus.RD1_E       = a;
      bus.RD2_E       = b;
      bus.Imm_Ext_E   = imm;
      bus.ALUSrcE     = alusrc;
      bus.ForwardA_E  = fa;
      bus.ForwardB_E  = fb;
      bus.ResultW     = rw;
      bus.RD_E        = rd;
      bus.RegWriteE   = 1'b1;
      bus.PCPlus4E    = 32'h400 + {25'h0, rd, 2'b00};
      e = '{res: exp_res, rd: rd, pc4: bus.PCPlus4E, stalls: 0};
      sb_q.push_back(e);
      collect(tag);
   endtask

   task automatic issue_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
      exp_t e;
      clear_e();
      bus.MulDivE   = 1'b1;
      bus.MulDivOpE = op;
      bus.RD1_E     = a;
      bus.RD2_E     = b;
      bus.ALUSrcE   = 1'b1;
      bus.Imm_Ext_E = 32'hDEAD_BEEF;
      bus.JumpE     = 1'b1;
      bus.RD_E      = rd;
      bus.RegWriteE = 1'b1;
      bus.PCPlus4E  = 32'h200 + {25'h0, rd, 2'b00};
      e = '{res: ref_md(op, a, b), rd: rd, pc4: bus.PCPlus4E,
            stalls: (op[2] && b == 32'h0) ? 1 : 33};
      sb_q.push_back(e);
      #1;
      check({tag, " PCSrcE suppressed"}, {31'h0, bus.PCSrcE}, 32'h0);
      collect(tag);
   endtask

   task automatic branch_chk(input string tag, input logic [2:0] bop, input logic [31:0] a,
                             input logic [31:0] b, input logic jump, input logic exp_src);
      clear_e();
      bus.BranchE   = ~jump;
      bus.JumpE     = jump;
      bus.BranchOpE = bop;
      bus.RD1_E     = a;
      bus.RD2_E     = b;
      bus.PCE       = 32'h100;
      bus.Imm_Ext_E = 32'h20;
      #1;
      check({tag, " PCSrcE"}, {31'h0, bus.PCSrcE}, {31'h0, exp_src});
      check({tag, " PCTargetE"}, bus.PCTargetE, 32'h120);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      clear_e();
      repeat (2) @(posedge clk);
      #1;
      check("reset StallE", {31'h0, bus.StallE}, 32'h0);
      check("reset ALUResultM", bus.ALUResultM, 32'h0);
      check("reset RegWriteM", {31'h0, bus.RegWriteM}, 32'h0);
      check("reset RD_M", {27'h0, bus.RD_M}, 32'h0);
      check("reset WriteDataM", bus.WriteDataM, 32'h0);
      rst = 1'b1;

      issue_alu("add", 3'b000, 32'd5, 32'd0, 32'd7, 1'b1, 2'b00, 2'b00, 32'd0, 5'd3, 32'd12);
      issue_alu("sub fwd", 3'b001, 32'd1, 32'd2, 32'd0, 1'b0, 2'b01, 2'b10, 32'd50, 5'd4,
                32'd38);
      check("sub WriteDataM", bus.WriteDataM, 32'd12);
      issue_alu("and", 3'b010, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 2'b00, 2'b11,
                32'd0, 5'd5, 32'h0000_F000);
      issue_alu("or", 3'b011, 32'h0000_F0F0, 32'h0000_0F0F, 32'd0, 1'b0, 2'b00, 2'b00,
                32'd0, 5'd6, 32'h0000_FFFF);
      issue_alu("slt neg", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0,
                5'd7, 32'd1);
      issue_alu("slt pos", 3'b101, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0,
                5'd8, 32'd0);

      branch_chk("blt", 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
      branch_chk("bltu", 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
      branch_chk("beq", 3'b000, 32'd5, 32'd5, 1'b0, 1'b1);
      branch_chk("bne", 3'b001, 32'd5, 32'd5, 1'b0, 1'b0);
      branch_chk("bge", 3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
      branch_chk("bgeu", 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
      branch_chk("op010", 3'b010, 32'd5, 32'd5, 1'b0, 1'b0);
      branch_chk("jal", 3'b001, 32'd5, 32'd5, 1'b1, 1'b1);

      issue_md("mul", 3'b000, 32'h0001_0000, 32'h0001_0003, 5'd9);
      issue_md("divu", 3'b101, 32'd100, 32'd7, 5'd10);
      issue_md("remu", 3'b111, 32'd100, 32'd7, 5'd11);
      issue_md("divu by 0", 3'b101, 32'd100, 32'd0, 5'd12);
      issue_md("remu by 0", 3'b111, 32'h1234_5678, 32'd0, 5'd13);
      issue_md("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14);
      issue_md("mul big", 3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15);
      issue_md("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
      issue_md("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
      issue_md("rem neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd18);
      issue_md("div neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd19);
      issue_md("mulh", 3'b001, 32'hFFFF_FFFE, 32'd3, 5'd20);
      issue_md("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h8000_0002, 5'd21);
      issue_md("div by 0", 3'b100, 32'hFFFF_FFF9, 32'd0, 5'd22);
      issue_md("rem by 0", 3'b110, 32'hFFFF_FFF9, 32'd0, 5'd23);

      // abort a multiply in its tenth busy cycle
      clear_e();
      bus.MulDivE   = 1'b1;
      bus.MulDivOpE = 3'b000;
      bus.RD1_E     = 32'd3;
      bus.RD2_E     = 32'd5;
      bus.RD_E      = 5'd24;
      bus.RegWriteE = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      check("busy before reset", {31'h0, bus.StallE}, 32'h1);
      rst = 1'b0;
      #1;
      check("abort StallE", {31'h0, bus.StallE}, 32'h0);
      check("abort ALUResultM", bus.ALUResultM, 32'h0);
      check("abort RegWriteM", {31'h0, bus.RegWriteM}, 32'h0);
      check("abort PCPlus4M", bus.PCPlus4M, 32'h0);
      check("abort WriteDataM", bus.WriteDataM, 32'h0);
      bus.JumpE = 1'b1;
      #1;
      check("abort PCSrcE", {31'h0, bus.PCSrcE}, 32'h0);
      clear_e();
      @(posedge clk);
      #1;
      rst = 1'b1;
      issue_alu("add after reset", 3'b000, 32'd20, 32'd22, 32'd0, 1'b0, 2'b00, 2'b00, 32'd0,
                5'd25, 32'd42);
      clear_e();
      @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
